booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Sequential signed radix-4 Booth multiplier for the MultDiv unit. Retires 2 multiplier bits/cycle.
//  Sits beside the divider and is launched by the ALU/stall logic with a start pulse.
//  Returns the full 2*WIDTH-bit product, a done pulse and an overflow flag for the exception path.
// PARAMETERS
//  WIDTH   32   operand width in bits; must be even and >= 4
// PORTS
//  clock         in   1          rising-edge clock
//  reset_n       in   1          asynchronous, active-low reset
//  start         in   1          launch request; sampled only in IDLE
//  multiplicand  in   WIDTH      signed operand M; captured on accepted start
//  multiplier    in   WIDTH      signed operand Q; captured on accepted start
//  busy          out  1          high from the cycle after an accepted start until done
//  done          out  1          one-cycle pulse: product/overflow valid
//  product       out  2*WIDTH    signed M*Q; held stable until the next accepted start
//  overflow      out  1          product does not fit in signed WIDTH; held with product
// BEHAVIOUR
//  Reset: async on reset_n low. State=IDLE; busy=0, done=0, product=0, overflow=0; all regs cleared.
//  FSM: IDLE --start--> RUN --(step count == WIDTH/2)--> DONE --> IDLE (unconditional).
//   - IDLE: start=1 captures M, Q; clears acc and q_prev; sets step count=0.
//   - RUN: one Booth step per cycle; busy=1.
//   - DONE: done=1 for exactly one cycle; product/overflow registered; busy=0.
//  Datapath: acc is WIDTH+2 bits signed; Q is a WIDTH-bit shift register; q_prev is 1 bit.
//  Step: digit = {Q[1:0], q_prev} decoded by booth_recode:
//   000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
//   M is sign-extended to WIDTH+2 before shift/negate; -x is ~x + 1 (carry-in).
//   Then {acc, Q, q_prev} is arithmetic-shifted right by 2.
//  Result: product = {acc[WIDTH-1:0], Q} after WIDTH/2 steps.
//   overflow = ~(all bits product[2*WIDTH-1:WIDTH-1] equal).
//  Latency: start accepted at edge 0; done high during cycle WIDTH/2+1 (WIDTH=32: 17).
//   Earliest next accepted start is the cycle after done (IDLE).
//  Boundaries:
//   - start while busy or in DONE: ignored; no capture, no effect.
//   - Operands may change after acceptance with no effect.
//   - M = Q = -2^(WIDTH-1): product = 2^(2*WIDTH-2), overflow=1. Acc width must absorb +2M without wrap.
//   - Zero operand: still full latency unless early termination is compiled in.
//   - reset_n low mid-RUN: immediate abort to IDLE; no done pulse; product=0.
//   - start held high continuously: back-to-back ops, one per WIDTH/2+2 cycles.
// CONFIGURATION
//  MULT_EARLY_TERM_EN (defined): in RUN, if the unconsumed Q bits and q_prev are all 0 or all 1,
//   the FSM jumps to DONE. It applies the remaining 2*(WIDTH/2-count) arithmetic right shift in one cycle.
//   Zero/-1 multiplier: done in cycle 2. Results are bit-identical to the full run.
//  Undefined: fixed latency WIDTH/2+1; no early-exit logic synthesised.
// STRUCTURE
//  Shared include mult_defs.vh holds:
//   - FSM state encodings ST_IDLE/ST_RUN/ST_DONE (2 bits);
//   - recode op encodings OP_NOP/OP_ADD1/OP_ADD2/OP_SUB1/OP_SUB2;
//   - step-counter width function clog2(WIDTH/2+1).
//  Sub-module booth_recode: combinational 3-bit digit -> {nop, sub, sl}; instantiated once.
//  Top holds FSM, counter, acc/Q/q_prev registers and the adder.
// TESTING
//  1. WIDTH=32, M=3, Q=5, start pulse -> done in cycle 17; product=15; overflow=0.
//  2. M=-7, Q=6 -> product=-42 (0xFFFF_FFFF_FFFF_FFD6); overflow=0.
//  3. M=Q=0x8000_0000 -> product=0x4000_0000_0000_0000; overflow=1.
//     Also M=0x10000, Q=0x10000 -> overflow=1.
//  4. Second start asserted at cycle 5 of a busy op -> ignored.
//     First result correct; no extra done.
//  5. reset_n low at cycle 8 of RUN -> busy=0, done never pulses, product=0.
//     Next op after release gives the correct result.
//  6. Random signed sweep (1000 pairs, incl. 0/-1/min/max) vs reference M*Q:
//     - with MULT_EARLY_TERM_EN: Q=0 done at cycle 2; results identical;
//     - without it: every op takes 17 cycles.

Source files
------------

// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, recode ops
// and the step-counter width helper.
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ADD1 = 3'd1,
    OP_ADD2 = 3'd2,
    OP_SUB1 = 3'd3,
    OP_SUB2 = 3'd4
  } op_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // Counter must hold 0..width/2 inclusive.
  function automatic int cnt_width(input int width);
    return clog2(width / 2 + 1);
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth digit decoder: 3-bit overlapping digit -> {nop, sub, sl}.
module booth_recode
  import booth_mult_seq_pkg::*;
(
  input  logic [2:0] digit,
  output logic       nop,
  output logic       sub,
  output logic       sl
);

  op_e op;

  always_comb begin
    case (digit)
      3'b000, 3'b111: op = OP_NOP;
      3'b001, 3'b010: op = OP_ADD1;
      3'b011:         op = OP_ADD2;
      3'b100:         op = OP_SUB2;
      default:        op = OP_SUB1;
    endcase
  end

  assign nop = (op == OP_NOP);
  assign sub = (op == OP_SUB1) || (op == OP_SUB2);
  assign sl  = (op == OP_ADD2) || (op == OP_SUB2);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-4 Booth multiplier, two multiplier bits per cycle.
// Optional MULT_EARLY_TERM_EN: finish early once the remaining multiplier bits are uniform.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int AW    = WIDTH + 2;

  state_e             state, state_n;
  logic [WIDTH-1:0]   m_q, m_n;
  logic [AW-1:0]      acc, acc_n;
  logic [WIDTH-1:0]   q_sr, q_n;
  logic               q_prev, q_prev_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [2*WIDTH-1:0] product_q;
  logic               overflow_q;
  logic               load_result;

  logic               rc_nop, rc_sub, rc_sl;
  logic [AW-1:0]      m_ext, addend, addend_x, sum;
  logic [2*WIDTH-1:0] result_n;
  logic [WIDTH:0]     result_hi;
  logic               overflow_n;

  booth_recode u_recode (
    .digit ({q_sr[1:0], q_prev}),
    .nop   (rc_nop),
    .sub   (rc_sub),
    .sl    (rc_sl)
  );

  // Sign-extended by two so +/-2M never wraps, even for M = -2^(WIDTH-1).
  assign m_ext    = {{2{m_q[WIDTH-1]}}, m_q};
  assign addend   = rc_sl ? {m_ext[AW-2:0], 1'b0} : m_ext;
  assign addend_x = rc_nop ? '0 : (rc_sub ? ~addend : addend);
  assign sum      = acc + addend_x + {{(AW-1){1'b0}}, rc_sub};

`ifdef MULT_EARLY_TERM_EN
  int                         rem;
  logic                       uniform;
  logic signed [AW+WIDTH-1:0] full;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    m_n         = m_q;
    acc_n       = acc;
    q_n         = q_sr;
    q_prev_n    = q_prev;
    count_n     = count;
    load_result = 1'b0;
`ifdef MULT_EARLY_TERM_EN
    rem     = WIDTH - 2 * int'(count);
    uniform = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < rem && q_sr[i] != q_prev) uniform = 1'b0;
    end
    full = $signed({acc, q_sr}) >>> rem;
`endif

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          m_n      = multiplicand;
          q_n      = multiplier;
          acc_n    = '0;
          q_prev_n = 1'b0;
          count_n  = '0;
          state_n  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Add the digit's multiple, then shift {acc, Q, q_prev} right by two.
        acc_n    = {sum[AW-1], sum[AW-1], sum[AW-1:2]};
        q_n      = {sum[1:0], q_sr[WIDTH-1:2]};
        q_prev_n = q_sr[1];
        count_n  = count + CNT_W'(1);
        if (count == CNT_W'(STEPS - 1)) begin
          state_n     = ST_DONE;
          load_result = 1'b1;
        end
`ifdef MULT_EARLY_TERM_EN
        // Remaining digits are all +0, so the rest of the run is a pure shift.
        if (uniform) begin
          acc_n       = full[AW+WIDTH-1:WIDTH];
          q_n         = full[WIDTH-1:0];
          q_prev_n    = q_prev;
          count_n     = CNT_W'(STEPS);
          state_n     = ST_DONE;
          load_result = 1'b1;
        end
`endif
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign result_n   = {acc_n[WIDTH-1:0], q_n};
  assign result_hi  = result_n[2*WIDTH-1:WIDTH-1];
  assign overflow_n = ~((&result_hi) | ~(|result_hi));

  // NOTE: operand and datapath registers are cleared on reset as well, so an
  // abort mid-run leaves no stale state visible anywhere.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      m_q        <= '0;
      acc        <= '0;
      q_sr       <= '0;
      q_prev     <= 1'b0;
      count      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values.
      state  <= state_n;
      m_q    <= m_n;
      acc    <= acc_n;
      q_sr   <= q_n;
      q_prev <= q_prev_n;
      count  <= count_n;
      if (load_result) begin
        product_q  <= result_n;
        overflow_q <= overflow_n;
      end
    end
  end

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: driver pushes expected products from a
// plain-arithmetic model, a monitor pops and compares on every done pulse.
module tb_booth_mult_seq;

  localparam int WIDTH    = 32;
  localparam int STEPS    = WIDTH / 2;
  localparam int MAX_WAIT = 40;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_INJECT = 1;
  localparam int MODE_ABORT  = 2;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [WIDTH-1:0]     multiplicand = '0;
  logic [WIDTH-1:0]     multiplier = '0;
  logic                 busy, done, overflow;
  logic [2*WIDTH-1:0]   product;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic [63:0] prod;
    logic        ovf;
    int          t0;
    logic [31:0] q;
  } exp_t;

  exp_t sb[$];

  booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Reference: signed product of the two operands, overflow if outside signed 32-bit range.
  function automatic exp_t model(input logic [31:0] m, input logic [31:0] q, input int t0);
    exp_t   e;
    longint a, b, p;
    a = longint'($signed(m));
    b = longint'($signed(q));
    p = a * b;
    e.prod = p;
    e.ovf  = (p >= (longint'(1) <<< 31)) || (p < -(longint'(1) <<< 31));
    e.t0   = t0;
    e.q    = q;
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    int s;
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: begin
        s = int'($urandom_range(0, 15)) - 8;
        return 32'(s);
      end
      default: return $urandom;
    endcase
  endfunction

  // Issues one op at the next negedge (DUT must be idle) and waits for done.
  task automatic do_op(input logic [31:0] m, input logic [31:0] q, input int mode,
                       input bit keep_start, output int done_cycle);
    int n;
    done_cycle = 0;
    @(negedge clock);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    if (mode != MODE_ABORT) sb.push_back(model(m, q, cycle_cnt + 1));
    @(posedge clock);
    @(negedge clock);
    start        = keep_start;
    multiplicand = $urandom;
    multiplier   = $urandom;
    n = 1;
    check("busy_run", {63'd0, busy}, 64'd1);
    while (!done && n < MAX_WAIT) begin
      if (mode == MODE_INJECT && n == 5) begin
        start        = 1'b1;
        multiplicand = 32'h0BAD_F00D;
        multiplier   = 32'h0000_0100;
      end
      if (mode == MODE_INJECT && n == 6) start = 1'b0;
      if (mode == MODE_ABORT && n == 8) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        check("abort_overflow", {63'd0, overflow}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        return;
      end
      @(negedge clock);
      n++;
    end
    if (mode == MODE_INJECT) start = 1'b0;
    check("done_seen", {63'd0, done}, 64'd1);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    done_cycle = cycle_cnt;
  endtask

  // Monitor: every done pulse must match the oldest outstanding op.
  always @(negedge clock) begin
    exp_t e;
    int   lat;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL spurious_done: got done=1 with no op pending, want done=0 (cycle %0d)", cycle_cnt);
      end else begin
        e   = sb.pop_front();
        lat = cycle_cnt - e.t0 + 1;
        check("product", product, e.prod);
        check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
`ifdef MULT_EARLY_TERM_EN
        if (e.q == 32'h0) check("latency_zero_q", 64'(lat), 64'd2);
        else              check("latency_bound", {63'd0, (lat >= 2 && lat <= STEPS + 1)}, 64'd1);
`else
        check("latency", 64'(lat), 64'(STEPS + 1));
`endif
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached, want bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dir_m [10];
    logic [31:0] dir_q [10];
    int          dc, prev_dc;

    dir_m = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0001_0000, 32'h0000_0000,
              32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    dir_q = '{32'd5, 32'd6, 32'h8000_0000, 32'h0001_0000, 32'h1234_5678,
              32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};

    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) do_op(dir_m[i], dir_q[i], MODE_NORMAL, 1'b0, dc);

    // Start pulse during a busy op must be ignored.
    do_op(32'h0000_1234, 32'h0000_5678, MODE_INJECT, 1'b0, dc);
    repeat (3) @(negedge clock);

    // Reset mid-run, then a clean op afterwards.
    do_op(32'h1357_9BDF, 32'h5A5A_A5A5, MODE_ABORT, 1'b0, dc);
    do_op(32'hFFFF_0001, 32'h0001_0003, MODE_NORMAL, 1'b0, dc);

    // Start held high: back-to-back ops.
    prev_dc = 0;
    for (int i = 0; i < 5; i++) begin
      do_op(rand_op(), $urandom | 32'h4000_0001, MODE_NORMAL, (i != 4), dc);
`ifndef MULT_EARLY_TERM_EN
      if (i > 0) check("held_period", 64'(dc - prev_dc), 64'(STEPS + 2));
`endif
      prev_dc = dc;
    end

    for (int i = 0; i < 1000; i++) do_op(rand_op(), rand_op(), MODE_NORMAL, 1'b0, dc);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
